// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, defaults and Gray helpers for the step controller
// Contents: state_t FSM encoding, default widths, all-ones terminal value, bin2gray().
package gray_pkg;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned DEF_CNT_W = 8;

  // All-ones binary terminal value; users slice it down to their own width.
  localparam logic [31:0] BIN_TERM_RAW = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_ctrl_if.sv
// rtl/gray_step_ctrl_if.sv - command/status bundle between host and step controller
// master: drives start/steps/pause/abort, observes busy/done/gray/wraps/overflow.
// slave:  the controller side of the same signals.
interface gray_step_ctrl_if #(
  parameter int unsigned WIDTH = gray_pkg::DEF_WIDTH,
  parameter int unsigned CNT_W = gray_pkg::DEF_CNT_W
);
  logic             start;
  logic [CNT_W-1:0] steps;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gray;
  logic [CNT_W-1:0] wraps;
  logic             overflow;

  modport master (
    output start, steps, pause, abort,
    input  busy, done, gray, wraps, overflow
  );

  modport slave (
    input  start, steps, pause, abort,
    output busy, done, gray, wraps, overflow
  );
endinterface

// File: rtl/gray_core.sv
// rtl/gray_core.sv - binary counter with registered Gray encoding, one step per enabled cycle
// Ports: clk, reset (sync, active-high), en (advance), gray (registered code),
//        wrap (combinational: this enabled edge moves all-ones back to zero).
module gray_core
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TERM = BIN_TERM_RAW[WIDTH-1:0];

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;

  assign bin_next = bin + WIDTH'(1);
  assign wrap     = en && (bin == TERM);

  // Gray is encoded from the next binary value so both registers move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= '0;
      gray <= '0;
    end else if (en) begin
      bin  <= bin_next;
      gray <= WIDTH'(bin2gray(32'(bin_next)));
    end
  end

endmodule

// File: rtl/gray_step_ctrl.sv
// rtl/gray_step_ctrl.sv - sequences a Gray counter core through a commanded number of steps
// Ports: clk, reset (sync, active-high), bus (slave side of gray_step_ctrl_if:
//        start/steps/pause/abort in; busy/done/gray/wraps/overflow out).
module gray_step_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  gray_step_ctrl_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             core_en;
  logic             core_wrap;

  // Abort beats pause beats advance; the core only moves on a clean RUN edge.
  assign core_en = (state == RUN) && !bus.abort && !bus.pause;

  gray_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (core_en),
    .gray  (bus.gray),
    .wrap  (core_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      bus.wraps    <= '0;
      bus.overflow <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      // core_wrap can only fire in RUN, so it never collides with the IDLE clear.
      if (core_wrap) begin
        bus.overflow <= 1'b1;
        if (bus.wraps != '1) begin
          bus.wraps <= bus.wraps + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.wraps    <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b1;
            if (bus.steps != '0) begin
              remaining <= bus.steps;
              state     <= RUN;
            end else begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end

        RUN: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.pause) begin
            state <= HOLD;
          end else begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end

        HOLD: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (!bus.pause) begin
            state <= RUN;
          end
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_ctrl.sv
// tb/tb_gray_step_ctrl.sv - self-checking bench for gray_step_ctrl
module tb_gray_step_ctrl;

  logic clk;
  logic reset;

  gray_step_ctrl_if #(.WIDTH(3), .CNT_W(8)) bus ();

  gray_step_ctrl #(.WIDTH(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int run_id;
  int pos;         // total advances since reset
  int last_wraps;  // wraps reported by the most recent run
  int gray_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s run=%0d observed=%0h expected=%0h", tag, run_id, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances completed after edge e of a run: pausing for L edges after
  // advance m costs L+1 edges (enter HOLD, stay, return to RUN).
  function automatic int adv_at(input int e, input int n, input int m, input int l);
    int shift;
    int r;
    shift = (l > 0) ? l + 1 : 0;
    if (l == 0 || e <= m) r = e;
    else if (e <= m + shift) r = m;
    else r = e - shift;
    if (r > n) r = n;
    return r;
  endfunction

  task automatic check_pos(input int adv);
    int w;
    w = (pos + adv) / 8 - pos / 8;
    if (w > 255) w = 255;
    check("gray", 32'(bus.gray), 32'(gray_seq[(pos + adv) % 8]));
    check("wraps", 32'(bus.wraps), 32'(w));
    check("overflow", 32'(bus.overflow), 32'(w != 0));
  endtask

  // One command: n steps, pause for l edges after advance m, abort at edge a (0 = none).
  task automatic run(input int n, input int m, input int l, input int a);
    int shift;
    int e_end;
    int last;
    int adv;
    run_id++;
    shift = (l > 0) ? l + 1 : 0;
    e_end = (n == 0) ? 0 : n + shift;
    last  = (a > 0) ? a : e_end + 1;
    bus.start = 1'b1;
    bus.steps = 8'(n);
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    adv = 0;
    for (int e = 0; e <= last; e++) begin
      if (e > 0) begin
        // Stray starts while busy must be ignored and never reload steps.
        bus.start = ($urandom_range(0, 2) == 0);
        bus.steps = 8'($urandom);
        bus.pause = (l > 0 && e > m && e <= m + l);
        bus.abort = (e == a);
      end
      tick();
      adv = (a > 0 && e >= a) ? adv_at(a - 1, n, m, l) : adv_at(e, n, m, l);
      check("busy", 32'(bus.busy), 32'((a > 0 && e >= a) ? 0 : (e <= e_end)));
      check("done", 32'(bus.done), 32'(a == 0 && e == e_end));
      check_pos(adv);
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    last_wraps = (pos + adv) / 8 - pos / 8;
    if (last_wraps > 255) last_wraps = 255;
    pos = pos + adv;
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_gray", 32'(bus.gray), 32'd0);
    check("rst_wraps", 32'(bus.wraps), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    int n, m, l, a, shift, e_end;
    n_cmp      = 0;
    n_fail     = 0;
    run_id     = 0;
    pos        = 0;
    last_wraps = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.steps  = '0;
    bus.pause  = 1'b0;
    bus.abort  = 1'b0;
    tick();
    tick();
    check_reset_state();
    reset = 1'b0;

    run(3, 0, 0, 0);     // 001, 011, 010
    run(5, 0, 0, 0);     // reaches position 8: first wrap
    run(8, 0, 0, 0);     // full period from 000
    run(1, 0, 0, 0);     // flags cleared, single step
    run(5, 2, 3, 0);     // pause after 2nd advance
    run(6, 2, 0, 3);     // abort right after 2nd advance
    run(0, 0, 0, 0);     // zero-step command
    run(20, 0, 0, 0);    // two wraps, ends on 110
    run(4, 1, 2, 3);     // abort while in HOLD

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 40);
      l = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      m = (l > 0) ? $urandom_range(1, n - 1) : 0;
      shift = (l > 0) ? l + 1 : 0;
      e_end = (n == 0) ? 0 : n + shift;
      a = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, e_end) : 0;
      run(n, m, l, a);
    end

    // Abort while idle leaves everything untouched.
    run_id++;
    bus.abort = 1'b1;
    tick();
    tick();
    bus.abort = 1'b0;
    check("idle_abort_busy", 32'(bus.busy), 32'd0);
    check("idle_abort_done", 32'(bus.done), 32'd0);
    check("idle_abort_gray", 32'(bus.gray), 32'(gray_seq[pos % 8]));
    check("idle_abort_wraps", 32'(bus.wraps), 32'(last_wraps));

    // Reset in the middle of a run, with pause and abort also asserted.
    run_id++;
    bus.start = 1'b1;
    bus.steps = 8'd6;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre_reset_gray", 32'(bus.gray), 32'(gray_seq[(pos + 2) % 8]));
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset     = 1'b1;
    bus.pause = 1'b1;
    bus.abort = 1'b1;
    tick();
    check_reset_state();
    reset     = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    tick();
    check_reset_state();
    pos = 0;

    run(3, 0, 0, 0);     // position restarts from zero after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
